heading_sample_scheduler: RTL and testbench

Controller that sequences the heading datapath. It issues a periodic sample request and waits for the resulting heading with a timeout. Samples taken at excessive tilt, or with an out-of-range heading, are rejected. Accepted samples pass through a wrap-aware exponential smoother, and the block publishes a stable filtered heading (0-359) for the display/UI logic.

---
 rtl/heading_sample_scheduler_pkg.sv | 16 +
 rtl/heading_sample_scheduler_wrap_filter.sv | 44 ++++
 rtl/heading_sample_scheduler.sv | 160 ++++++++++++++++
 tb/tb_heading_sample_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/heading_sample_scheduler_pkg.sv
// Shared types and constants for the heading sample scheduler.
package heading_sample_scheduler_pkg;

    localparam int HDG_W   = 9;
    localparam int DEG_360 = 360;
    localparam int DEG_180 = 180;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PERIOD,
        ST_REQ,
        ST_WAIT,
        ST_FILTER
    } state_t;

endpackage

// File: rtl/heading_sample_scheduler_wrap_filter.sv
// Wrap-aware exponential smoothing step: moves prev_hdg toward sample_hdg
// along the shorter arc by round(delta / 2^SHIFT), result kept in 0..359.
module heading_wrap_filter
    import heading_sample_scheduler_pkg::*;
#(
    parameter int SHIFT = 2
) (
    input  logic [HDG_W-1:0] prev_hdg,
    input  logic [HDG_W-1:0] sample_hdg,
    output logic [HDG_W-1:0] next_hdg
);

    // 11 bits signed covers -359..+539 for every intermediate value
    localparam logic signed [10:0] D360  = 11'(DEG_360);
    localparam logic signed [10:0] D180  = 11'(DEG_180);
    // half of 2^SHIFT for round-half-up; evaluates to 0 when SHIFT is 0
    localparam logic signed [10:0] ROUND = 11'((2 ** SHIFT) / 2);
    localparam logic signed [10:0] ZERO  = 11'sd0;

    logic signed [10:0] delta_raw;
    logic signed [10:0] delta;
    logic signed [10:0] step;
    logic signed [10:0] sum;
    logic signed [10:0] wrapped;

    // shortest-arc delta (-179..180), rounded shift, then re-wrap into 0..359
    always_comb begin
        delta_raw = $signed({2'b00, sample_hdg}) - $signed({2'b00, prev_hdg});
        delta     = delta_raw;
        if (delta_raw > D180)
            delta = delta_raw - D360;
        else if (delta_raw <= -D180)
            delta = delta_raw + D360;
        step    = (delta + ROUND) >>> SHIFT;
        sum     = $signed({2'b00, prev_hdg}) + step;
        wrapped = sum;
        if (sum < ZERO)
            wrapped = sum + D360;
        else if (sum >= D360)
            wrapped = sum - D360;
        next_hdg = wrapped[HDG_W-1:0];
    end

endmodule

// File: rtl/heading_sample_scheduler.sv
// Periodic heading sampler: requests a measurement, waits with timeout,
// rejects tilted or out-of-range samples and smooths accepted headings.
module heading_sample_scheduler
    import heading_sample_scheduler_pkg::*;
#(
    parameter int PERIOD_CYCLES  = 400000,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SHIFT          = 2,
    parameter int TILT_MAX       = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear_err,
    output logic             sample_req,
    input  logic [HDG_W-1:0] hdg_in,
    input  logic [8:0]       pitch_in,
    input  logic [8:0]       roll_in,
    input  logic             hdg_valid,
    output logic [HDG_W-1:0] heading_out,
    output logic             heading_valid,
    output logic             tilt_reject,
    output logic             timeout_err,
    output logic [7:0]       miss_count
);

    // one counter serves both the period wait and the response timeout
    localparam int CNT_MAX = (PERIOD_CYCLES > TIMEOUT_CYCLES) ? PERIOD_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic signed [9:0] TLIM  = 10'(TILT_MAX);
    localparam logic signed [9:0] NTLIM = -TLIM;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [HDG_W-1:0]   sample_q;
    logic [HDG_W-1:0]   filt_next;
    logic               primed;
    logic               cnt_clr, cnt_inc;
    logic               capture, reject, timeout, update;
    logic signed [9:0]  pitch_s, roll_s;
    logic               bad_sample;

    assign pitch_s    = $signed({pitch_in[8], pitch_in});
    assign roll_s     = $signed({roll_in[8], roll_in});
    assign bad_sample = (pitch_s > TLIM) || (pitch_s < NTLIM) ||
                        (roll_s  > TLIM) || (roll_s  < NTLIM) ||
                        (hdg_in >= HDG_W'(DEG_360));

    heading_wrap_filter #(.SHIFT(SHIFT)) u_filter (
        .prev_hdg   (heading_out),
        .sample_hdg (sample_q),
        .next_hdg   (filt_next)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    // next-state and per-cycle control strobes
    always_comb begin
        state_n    = state;
        sample_req = (state == ST_REQ);
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        capture    = 1'b0;
        reject     = 1'b0;
        timeout    = 1'b0;
        update     = 1'b0;
        if (state != ST_IDLE && !enable) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state_n = ST_PERIOD;
                        cnt_clr = 1'b1;
                    end
                end
                ST_PERIOD: begin
                    if (cnt == P_LAST)
                        state_n = ST_REQ;
                    else
                        cnt_inc = 1'b1;
                end
                ST_REQ: begin
                    state_n = ST_WAIT;
                    cnt_clr = 1'b1;
                end
                ST_WAIT: begin
                    // a response on the timeout cycle still counts
                    if (hdg_valid) begin
                        if (bad_sample) begin
                            reject  = 1'b1;
                            state_n = ST_PERIOD;
                            cnt_clr = 1'b1;
                        end else begin
                            capture = 1'b1;
                            state_n = ST_FILTER;
                        end
                    end else if (cnt == T_LAST) begin
                        timeout = 1'b1;
                        state_n = ST_PERIOD;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                ST_FILTER: begin
                    update  = 1'b1;
                    state_n = ST_PERIOD;
                    cnt_clr = 1'b1;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // counters, sample capture, filtered heading and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            sample_q      <= '0;
            primed        <= 1'b0;
            heading_out   <= '0;
            heading_valid <= 1'b0;
            tilt_reject   <= 1'b0;
            timeout_err   <= 1'b0;
            miss_count    <= '0;
        end else begin
            if (cnt_clr)
                cnt <= '0;
            else if (cnt_inc)
                cnt <= cnt + CNT_W'(1);
            if (capture)
                sample_q <= hdg_in;
            if (update)
                heading_out <= primed ? filt_next : sample_q;
            // dropping enable forgets filter history so the next sample loads directly
            if (!enable)
                primed <= 1'b0;
            else if (update)
                primed <= 1'b1;
            heading_valid <= update;
            tilt_reject   <= reject;
            if (timeout)
                timeout_err <= 1'b1;
            else if (clear_err)
                timeout_err <= 1'b0;
            if ((timeout || reject) && miss_count != 8'hFF)
                miss_count <= miss_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_heading_sample_scheduler.sv
// Randomized bench for heading_sample_scheduler against a behavioural model.
module tb_heading_sample_scheduler;

    localparam int P  = 8;
    localparam int T  = 16;
    localparam int S  = 2;
    localparam int TM = 30;

    logic       clk = 1'b0;
    logic       reset, enable, clear_err, hdg_valid;
    logic [8:0] hdg_in, pitch_in, roll_in;
    logic       sample_req, heading_valid, tilt_reject, timeout_err;
    logic [8:0] heading_out;
    logic [7:0] miss_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_req = 0;

    // behavioural model state
    int m_head = 0;
    int m_miss = 0;
    bit m_primed = 0;
    bit m_err = 0;

    always #5 clk = ~clk;

    heading_sample_scheduler #(
        .PERIOD_CYCLES(P), .TIMEOUT_CYCLES(T), .SHIFT(S), .TILT_MAX(TM)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear_err(clear_err),
        .sample_req(sample_req), .hdg_in(hdg_in), .pitch_in(pitch_in),
        .roll_in(roll_in), .hdg_valid(hdg_valid), .heading_out(heading_out),
        .heading_valid(heading_valid), .tilt_reject(tilt_reject),
        .timeout_err(timeout_err), .miss_count(miss_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // smoothing step from the arithmetic rules: shortest arc, round half up, mod 360
    function automatic int ref_filter(input int prev, input int smp);
        int d, st, n;
        d = ((smp - prev + 540) % 360) - 180;
        if (d == -180) d = 180;
        n = 1 << S;
        st = (d + n / 2 + 1024 * n) / n - 1024;
        return ((prev + st) % 360 + 360) % 360;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    task automatic chk_reset_state();
        chk("rst_req", sample_req, 0);
        chk("rst_head", heading_out, 0);
        chk("rst_hv", heading_valid, 0);
        chk("rst_tr", tilt_reject, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_miss", miss_count, 0);
    endtask

    // wait for the request pulse, throwing ignored hdg_valid noise meanwhile
    task automatic wait_req();
        int n;
        n = 0;
        while (sample_req !== 1'b1 && n < P + T + 8) begin
            if ($urandom_range(0, 3) == 0) begin
                hdg_valid = 1'b1;
                hdg_in    = 9'($urandom_range(0, 359));
                pitch_in  = '0;
                roll_in   = '0;
            end else begin
                hdg_valid = 1'b0;
            end
            step();
            n++;
        end
        hdg_valid = 1'b0;
        chk("req_cycle", cyc, exp_req);
    endtask

    // called on the request cycle; answer after d cycles or let it time out
    task automatic respond(input int d, input bit give, input int h, input int p,
                           input int rl, input bit clr_to);
        bit rej;
        step();
        chk("req_pulse", sample_req, 0);
        if (give) begin
            repeat (d - 1) step();
            hdg_valid = 1'b1;
            hdg_in    = h[8:0];
            pitch_in  = p[8:0];
            roll_in   = rl[8:0];
            step();
            hdg_valid = 1'b0;
            rej = (h >= 360) || (p > TM) || (p < -TM) || (rl > TM) || (rl < -TM);
            if (rej) begin
                m_miss = sat_inc(m_miss);
                chk("rej_pulse", tilt_reject, 1);
                chk("rej_novalid", heading_valid, 0);
                chk("rej_hold", heading_out, m_head);
                chk("rej_miss", miss_count, m_miss);
                exp_req = cyc + P;
            end else begin
                chk("acc_early", heading_valid, 0);
                chk("acc_norej", tilt_reject, 0);
                step();
                m_head   = m_primed ? ref_filter(m_head, h) : h;
                m_primed = 1;
                chk("acc_valid", heading_valid, 1);
                chk("acc_head", heading_out, m_head);
                chk("acc_err", timeout_err, m_err);
                chk("acc_miss", miss_count, m_miss);
                exp_req = cyc + P;
            end
        end else begin
            repeat (T - 1) step();
            if (clr_to) clear_err = 1'b1;
            step();
            clear_err = 1'b0;
            m_err  = 1;
            m_miss = sat_inc(m_miss);
            chk("to_err", timeout_err, 1);
            chk("to_miss", miss_count, m_miss);
            chk("to_novalid", heading_valid, 0);
            chk("to_hold", heading_out, m_head);
            exp_req = cyc + P;
        end
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        m_err = 0;
        chk("clr_err", timeout_err, 0);
    endtask

    // drop enable for one cycle so the next accepted sample loads directly
    task automatic restart();
        enable = 1'b0;
        step();
        m_primed = 0;
        chk("dis_hv", heading_valid, 0);
        enable = 1'b1;
        exp_req = cyc + 1 + P;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; clear_err = 1'b0; hdg_valid = 1'b0;
        hdg_in = '0; pitch_in = '0; roll_in = '0;
        repeat (3) step();
        chk_reset_state();
        reset  = 1'b0;
        enable = 1'b1;
        exp_req = cyc + 1 + P;

        // first sample loads directly
        wait_req(); respond(3, 1, 100, 0, 0, 0);
        chk("t1_head", heading_out, 100);

        // wrap upward across 0
        restart();
        wait_req(); respond(2, 1, 350, 0, 0, 0);
        wait_req(); respond(1, 1, 10, 0, 0, 0);  chk("wu_355", heading_out, 355);
        wait_req(); respond(4, 1, 10, 5, -5, 0); chk("wu_359", heading_out, 359);
        wait_req(); respond(1, 1, 10, 0, 0, 0);  chk("wu_2", heading_out, 2);

        // wrap downward and the +180 boundary
        restart();
        wait_req(); respond(1, 1, 5, 0, 0, 0);
        wait_req(); respond(1, 1, 355, 0, 0, 0); chk("wd_3", heading_out, 3);
        restart();
        wait_req(); respond(1, 1, 0, 0, 0, 0);
        wait_req(); respond(1, 1, 180, 0, 0, 0); chk("b180_45", heading_out, 45);

        // rejects: pitch, roll, heading range; tilt exactly at limit is accepted
        wait_req(); respond(2, 1, 90, 40, 0, 0);
        wait_req(); respond(2, 1, 90, 0, -31, 0);
        wait_req(); respond(2, 1, 360, 0, 0, 0);
        chk("rej_cnt", miss_count, 3);
        wait_req(); respond(2, 1, 45, 30, -30, 0);

        // timeout, clear, set-wins, response on the timeout cycle
        wait_req(); respond(0, 0, 0, 0, 0, 0);
        pulse_clear();
        wait_req(); respond(0, 0, 0, 0, 0, 1);
        pulse_clear();
        wait_req(); respond(T, 1, 60, 0, 0, 0);
        chk("lastcyc_err", timeout_err, 0);

        // disable during WAIT, late hdg_valid ignored
        wait_req(); step(); step();
        enable = 1'b0; step();
        m_primed = 0;
        hdg_valid = 1'b1; hdg_in = 9'd77; pitch_in = '0; roll_in = '0;
        step(); hdg_valid = 1'b0;
        chk("late_hv", heading_valid, 0);
        chk("late_tr", tilt_reject, 0);
        step();
        chk("late_hv2", heading_valid, 0);
        chk("late_head", heading_out, m_head);
        chk("late_miss", miss_count, m_miss);
        enable = 1'b1;
        exp_req = cyc + 1 + P;
        wait_req(); respond(2, 1, 200, 0, 0, 0);
        chk("reload_200", heading_out, 200);

        // reset while in FILTER
        wait_req(); step();
        hdg_valid = 1'b1; hdg_in = 9'd123; pitch_in = '0; roll_in = '0;
        step(); hdg_valid = 1'b0;
        reset = 1'b1; step();
        chk_reset_state();
        reset = 1'b0;
        m_head = 0; m_miss = 0; m_primed = 0; m_err = 0;
        exp_req = cyc + 1 + P;

        // randomized episodes
        for (int i = 0; i < 40; i++) begin
            int k, d, h, p, rl;
            k  = $urandom_range(0, 9);
            d  = $urandom_range(1, T);
            h  = (k == 0) ? $urandom_range(360, 511) : $urandom_range(0, 359);
            p  = int'($urandom_range(0, 76)) - 38;
            rl = int'($urandom_range(0, 76)) - 38;
            wait_req();
            respond(d, k != 9, h, p, rl, $urandom_range(0, 1) == 1);
            if (m_err && $urandom_range(0, 1) == 1) pulse_clear();
        end

        // miss_count saturation
        for (int i = 0; i < 260; i++) begin
            wait_req(); respond(1, 1, 50, 40, 0, 0);
        end
        chk("miss_sat", miss_count, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
